// File: rtl/test_rx_checker.sv
// Receive-side checker for the scrambler-based test packet stream: regenerates the
// expected payload, checks data, length and framing, and keeps saturating statistics.

module sata_scrambler #(
  parameter logic [15:0] G_INIT_VAL = 16'h55AA
) (
  input  logic        clk,
  input  logic        p_in_SOF,
  input  logic        p_in_en,
  output logic [31:0] p_out_result
);
  logic [15:0] lfsr_q, lfsr_d, adv;
  logic [31:0] word;

  // Galois LFSR x^16+x^15+x^13+x^4+1, 32 serial steps per output word
  always_comb begin
    word = '0;
    adv  = lfsr_q;
    for (int i = 0; i < 32; i++) begin
      word[i] = adv[15];
      adv     = {adv[14:0], 1'b0} ^ (adv[15] ? 16'hA011 : 16'h0000);
    end
    lfsr_d = lfsr_q;
    if (p_in_SOF)     lfsr_d = G_INIT_VAL;
    else if (p_in_en) lfsr_d = adv;
  end

  always_ff @(posedge clk) lfsr_q <= lfsr_d;

  assign p_out_result = word;
endmodule

module test_rx_checker #(
  parameter int TEST_DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [TEST_DATA_WIDTH-1:0] mac_rx_data,
  input  logic                       mac_rx_valid,
  input  logic                       mac_rx_sof,
  input  logic                       mac_rx_eof,
  input  logic [15:0]                pkt_size,
  input  logic                       clear,
  output logic                       locked,
  output logic                       err_data,
  output logic [31:0]                pkt_cnt,
  output logic [31:0]                err_data_cnt,
  output logic [15:0]                err_len_cnt,
  output logic [15:0]                err_frame_cnt
);
  typedef enum logic [1:0] {HUNT, IDLE, PKT} state_t;

  state_t      state_q, state_d;
  logic        locked_q, locked_d;
  logic        err_data_q, err_data_d;
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0] err_data_cnt_q, err_data_cnt_d;
  logic [15:0] err_len_cnt_q, err_len_cnt_d;
  logic [15:0] err_frame_cnt_q, err_frame_cnt_d;
  logic [15:0] len_q, len_d;
  logic [15:0] size_q, size_d;

  logic        cmp, scr_en, scr_sof, pkt_inc, len_bad, frm_bad;
  logic [15:0] len_inc;
  logic [31:0] scr_word;
  logic        kill;

  assign kill    = !rst_n || clear;
  assign len_inc = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;

  // Kill gating keeps the scrambler seeded during reset/clear so HUNT starts clean
  sata_scrambler #(.G_INIT_VAL(16'h55AA)) u_scr (
    .clk          (clk),
    .p_in_SOF     (scr_sof || kill),
    .p_in_en      (scr_en && !kill),
    .p_out_result (scr_word)
  );

  always_comb begin
    state_d  = state_q;
    locked_d = locked_q;
    len_d    = len_q;
    size_d   = size_q;
    cmp      = 1'b0;
    scr_en   = 1'b0;
    scr_sof  = (state_q == HUNT);
    pkt_inc  = 1'b0;
    len_bad  = 1'b0;
    frm_bad  = 1'b0;
    if (mac_rx_valid) begin
      case (state_q)
        HUNT, IDLE: begin
          if (mac_rx_sof) begin
            cmp      = 1'b1;
            scr_en   = 1'b1;
            scr_sof  = 1'b0;
            size_d   = pkt_size;
            len_d    = 16'd1;
            locked_d = 1'b1;
            if (mac_rx_eof) begin
              pkt_inc = 1'b1;
              len_bad = (pkt_size != 16'd1);
              state_d = IDLE;
            end else begin
              state_d = PKT;
            end
          end else if (state_q == IDLE) begin
            frm_bad = 1'b1;
          end
        end
        PKT: begin
          cmp    = 1'b1;
          scr_en = 1'b1;
          if (mac_rx_sof) begin
            // Aborted packet is dropped; this beat opens a fresh one
            frm_bad = 1'b1;
            size_d  = pkt_size;
            len_d   = 16'd1;
            if (mac_rx_eof) begin
              pkt_inc = 1'b1;
              len_bad = (pkt_size != 16'd1);
              state_d = IDLE;
            end
          end else begin
            len_d = len_inc;
            if (mac_rx_eof) begin
              pkt_inc = 1'b1;
              len_bad = (len_inc != size_q);
              state_d = IDLE;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    err_data_d      = cmp && (mac_rx_data != scr_word[TEST_DATA_WIDTH-1:0]);
    pkt_cnt_d       = (pkt_inc && pkt_cnt_q != '1) ? pkt_cnt_q + 32'd1 : pkt_cnt_q;
    err_data_cnt_d  = (err_data_d && err_data_cnt_q != '1) ? err_data_cnt_q + 32'd1 : err_data_cnt_q;
    err_len_cnt_d   = (len_bad && err_len_cnt_q != '1) ? err_len_cnt_q + 16'd1 : err_len_cnt_q;
    err_frame_cnt_d = (frm_bad && err_frame_cnt_q != '1) ? err_frame_cnt_q + 16'd1 : err_frame_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      state_q         <= HUNT;
      locked_q        <= 1'b0;
      err_data_q      <= 1'b0;
      pkt_cnt_q       <= '0;
      err_data_cnt_q  <= '0;
      err_len_cnt_q   <= '0;
      err_frame_cnt_q <= '0;
      len_q           <= '0;
      size_q          <= '0;
    end else begin
      state_q         <= state_d;
      locked_q        <= locked_d;
      err_data_q      <= err_data_d;
      pkt_cnt_q       <= pkt_cnt_d;
      err_data_cnt_q  <= err_data_cnt_d;
      err_len_cnt_q   <= err_len_cnt_d;
      err_frame_cnt_q <= err_frame_cnt_d;
      len_q           <= len_d;
      size_q          <= size_d;
    end
  end

  assign locked        = locked_q;
  assign err_data      = err_data_q;
  assign pkt_cnt       = pkt_cnt_q;
  assign err_data_cnt  = err_data_cnt_q;
  assign err_len_cnt   = err_len_cnt_q;
  assign err_frame_cnt = err_frame_cnt_q;
endmodule

// File: tb/tb_test_rx_checker.sv
// Directed bench for test_rx_checker: vector table plus multi-cycle stream sequences.

module tb_test_rx_checker;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mac_rx_data = '0;
  logic        mac_rx_valid = 1'b0;
  logic        mac_rx_sof = 1'b0;
  logic        mac_rx_eof = 1'b0;
  logic [15:0] pkt_size = '0;
  logic        clear = 1'b0;
  logic        locked, err_data;
  logic [31:0] pkt_cnt, err_data_cnt;
  logic [15:0] err_len_cnt, err_frame_cnt;

  int checks = 0;
  int errors = 0;
  logic [15:0] g;  // generator LFSR state

  test_rx_checker #(.TEST_DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .mac_rx_data(mac_rx_data), .mac_rx_valid(mac_rx_valid),
    .mac_rx_sof(mac_rx_sof), .mac_rx_eof(mac_rx_eof), .pkt_size(pkt_size), .clear(clear),
    .locked(locked), .err_data(err_data), .pkt_cnt(pkt_cnt), .err_data_cnt(err_data_cnt),
    .err_len_cnt(err_len_cnt), .err_frame_cnt(err_frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] scr_word(input logic [15:0] s);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 32; i++) begin
      w[i] = s[15];
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'hA011 : 16'h0000);
    end
    return w;
  endfunction

  function automatic logic [15:0] scr_next(input logic [15:0] s);
    for (int i = 0; i < 32; i++) s = {s[14:0], 1'b0} ^ (s[15] ? 16'hA011 : 16'h0000);
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic beat(input logic v, input logic s, input logic e, input logic gen,
                      input logic flip, input logic [15:0] sz);
    mac_rx_valid = v;
    mac_rx_sof   = s;
    mac_rx_eof   = e;
    pkt_size     = sz;
    mac_rx_data  = gen ? (scr_word(g) ^ {31'b0, flip}) : 32'h0;
    if (gen) g = scr_next(g);
    tick();
    mac_rx_valid = 1'b0;
    mac_rx_sof   = 1'b0;
    mac_rx_eof   = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    g = 16'h55AA;
  endtask

  task automatic chk_cnts(input string nm, input int p, input int d, input int l, input int f);
    chk({nm, " pkt_cnt"}, pkt_cnt, p);
    chk({nm, " err_data_cnt"}, err_data_cnt, d);
    chk({nm, " err_len_cnt"}, {16'h0, err_len_cnt}, l);
    chk({nm, " err_frame_cnt"}, {16'h0, err_frame_cnt}, f);
  endtask

  // 8-beat packets with 4 idle cycles between, optional single-bit corruption
  task automatic run(input string nm, input int n, input logic [15:0] csz,
                     input int fp, input int fb, output int pulses);
    logic fl;
    pulses = 0;
    for (int p = 1; p <= n; p++) begin
      for (int b = 1; b <= 8; b++) begin
        fl = (p == fp) && (b == fb);
        beat(1'b1, b == 1, b == 8, 1'b1, fl, csz);
        chk($sformatf("%s p%0d b%0d err_data", nm, p, b), {31'b0, err_data}, {31'b0, fl});
        if (err_data) pulses++;
      end
      for (int k = 0; k < 4; k++) begin
        tick();
        chk($sformatf("%s p%0d gap err_data", nm, p), {31'b0, err_data}, 32'h0);
        if (err_data) pulses++;
      end
    end
  endtask

  typedef struct {
    logic v, s, e, gen, flip;
    logic [15:0] sz;
    logic lk, ed;
    int p, d, l, f;
  } vec_t;

  vec_t vt[17];

  function automatic vec_t mk(logic v, logic s, logic e, logic gen, logic flip, logic [15:0] sz,
                              logic lk, logic ed, int p, int d, int l, int f);
    vec_t r;
    r.v = v; r.s = s; r.e = e; r.gen = gen; r.flip = flip; r.sz = sz;
    r.lk = lk; r.ed = ed; r.p = p; r.d = d; r.l = l; r.f = f;
    return r;
  endfunction

  initial begin
    int pulses;
    //            v  s  e  gn fl sz     lk ed  p  d  l  f
    vt[0]  = mk(1, 0, 0, 0, 0, 16'd0, 0, 0, 0, 0, 0, 0); // HUNT: stray beat ignored
    vt[1]  = mk(1, 1, 0, 1, 0, 16'd3, 1, 0, 0, 0, 0, 0);
    vt[2]  = mk(0, 0, 0, 0, 0, 16'd0, 1, 0, 0, 0, 0, 0); // gap inside packet
    vt[3]  = mk(1, 0, 0, 1, 0, 16'd0, 1, 0, 0, 0, 0, 0);
    vt[4]  = mk(1, 0, 1, 1, 0, 16'd0, 1, 0, 1, 0, 0, 0);
    vt[5]  = mk(1, 1, 0, 1, 1, 16'd2, 1, 1, 1, 1, 0, 0); // back-to-back, corrupted sof
    vt[6]  = mk(1, 0, 1, 1, 0, 16'd0, 1, 0, 2, 1, 0, 0);
    vt[7]  = mk(1, 0, 0, 0, 0, 16'd0, 1, 0, 2, 1, 0, 1); // IDLE stray beat
    vt[8]  = mk(1, 0, 1, 0, 0, 16'd0, 1, 0, 2, 1, 0, 2); // IDLE stray eof
    vt[9]  = mk(1, 1, 1, 1, 0, 16'd1, 1, 0, 3, 1, 0, 2); // 1-beat packet, size ok
    vt[10] = mk(1, 1, 1, 1, 0, 16'd2, 1, 0, 4, 1, 1, 2); // 1-beat packet, size 2
    vt[11] = mk(1, 1, 0, 1, 0, 16'd4, 1, 0, 4, 1, 1, 2);
    vt[12] = mk(1, 0, 0, 1, 1, 16'd0, 1, 1, 4, 2, 1, 2);
    vt[13] = mk(1, 1, 0, 1, 0, 16'd2, 1, 0, 4, 2, 1, 3); // sof inside PKT
    vt[14] = mk(1, 0, 1, 1, 0, 16'd0, 1, 0, 5, 2, 1, 3);
    vt[15] = mk(1, 1, 0, 1, 0, 16'd5, 1, 0, 5, 2, 1, 3);
    vt[16] = mk(1, 0, 1, 1, 0, 16'd0, 1, 0, 6, 2, 2, 3); // length 2 vs 5

    g = 16'h55AA;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("reset locked", {31'b0, locked}, 32'h0);
    chk("reset err_data", {31'b0, err_data}, 32'h0);
    chk_cnts("reset", 0, 0, 0, 0);

    for (int i = 0; i < 17; i++) begin
      beat(vt[i].v, vt[i].s, vt[i].e, vt[i].gen, vt[i].flip, vt[i].sz);
      chk($sformatf("vec%0d locked", i), {31'b0, locked}, {31'b0, vt[i].lk});
      chk($sformatf("vec%0d err_data", i), {31'b0, err_data}, {31'b0, vt[i].ed});
      chk_cnts($sformatf("vec%0d", i), vt[i].p, vt[i].d, vt[i].l, vt[i].f);
    end

    // clear coincident with a sof beat: the beat is ignored
    clear = 1'b1;
    beat(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd8);
    clear = 1'b0;
    g = 16'h55AA;
    chk("clear locked", {31'b0, locked}, 32'h0);
    chk_cnts("clear", 0, 0, 0, 0);

    // clean stream of 10 packets
    run("clean", 10, 16'd8, 0, 0, pulses);
    chk("clean pulses", pulses, 0);
    chk("clean locked", {31'b0, locked}, 32'h1);
    chk_cnts("clean", 10, 0, 0, 0);

    // single corrupted bit: packet 2, beat 3
    do_clear();
    run("flip", 10, 16'd8, 2, 3, pulses);
    chk("flip pulses", pulses, 1);
    chk_cnts("flip", 10, 1, 0, 0);

    // checker expects 9 beats, generator sends 8
    do_clear();
    run("len", 10, 16'd9, 0, 0, pulses);
    chk_cnts("len", 10, 0, 10, 0);

    // sof on beat 4 of an 8-beat packet; new packet runs beats 4..11
    do_clear();
    for (int b = 1; b <= 11; b++) begin
      beat(1'b1, b == 1 || b == 4, b == 11, 1'b1, 1'b0, 16'd8);
      if (b == 4) chk_cnts("abort sof", 0, 0, 0, 1);
    end
    chk_cnts("abort eof", 1, 0, 0, 1);

    // mid-packet reset coincident with a valid beat
    do_clear();
    run("pre-rst", 1, 16'd8, 0, 0, pulses);
    beat(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd8);
    beat(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd8);
    rst_n = 1'b0;
    beat(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd8);
    rst_n = 1'b1;
    chk("rst locked", {31'b0, locked}, 32'h0);
    chk_cnts("rst", 0, 0, 0, 0);
    beat(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd8);
    chk("rst hunt locked", {31'b0, locked}, 32'h0);
    chk("rst hunt frame", {16'h0, err_frame_cnt}, 32'h0);
    g = 16'h55AA;
    run("post-rst", 2, 16'd8, 0, 0, pulses);
    chk("post-rst locked", {31'b0, locked}, 32'h1);
    chk_cnts("post-rst", 2, 0, 0, 0);

    // saturate err_len_cnt with 1-beat packets whose expected size is 2
    do_clear();
    for (int i = 0; i < 65534; i++) beat(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd2);
    chk("sat pre err_len_cnt", {16'h0, err_len_cnt}, 32'h0000FFFE);
    for (int i = 0; i < 3; i++) beat(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd2);
    chk("sat err_len_cnt", {16'h0, err_len_cnt}, 32'h0000FFFF);
    chk("sat pkt_cnt", pkt_cnt, 32'd65537);
    chk("sat err_data_cnt", err_data_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/test_rx_checker.md
# test_rx_checker

Receive-side counterpart of the scrambler-based test packet generator. It sits downstream of the MAC receive path and consumes the framed test stream (data/valid/sof/eof). It regenerates the expected payload with its own `sata_scrambler` instance (G_INIT_VAL 16'h55AA) and checks every beat. It also checks packet length and framing, and keeps saturating statistics counters for link bring-up and BER soak tests.

## Interface
- TEST_DATA_WIDTH, 32, compared data width (1..32); low bits of scrambler word are used
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- mac_rx_data  in  TEST_DATA_WIDTH  received beat
- mac_rx_valid  in  1  beat qualifier; no backpressure, one beat per valid cycle
- mac_rx_sof  in  1  first beat of packet, meaningful only with valid
- mac_rx_eof  in  1  last beat of packet, meaningful only with valid
- pkt_size  in  16  expected beats per packet, sampled on sof beat
- clear  in  1  synchronous: zero counters, drop lock, return to HUNT
- locked  out  1  checker aligned to generator sequence
- err_data  out  1  one-cycle pulse, registered, for each mismatching beat
- pkt_cnt  out  32  completed packets (eof seen), saturating
- err_data_cnt  out  32  mismatching beats, saturating
- err_len_cnt  out  16  packets whose length != latched pkt_size, saturating
- err_frame_cnt  out  16  framing violations, saturating

## Operation
- Scrambler instance: `p_in_SOF` reloads the seed, and the first word appears on `p_out_result` the next cycle. Each `p_in_en` cycle advances one word.
- States:
  - HUNT (reset state): scrambler `p_in_SOF` held high, `en` low. A valid beat without sof is ignored, with no error counted.
  - IDLE: locked, between packets.
  - PKT: inside a packet.
- On a valid sof beat in HUNT or IDLE:
  - compare beat to the scrambler word, then assert `en`
  - latch `pkt_size`, set length counter to 1, `locked` <= 1
  - if eof is also set, close the packet in the same beat (length 1); otherwise go to PKT
- On a valid beat in PKT without sof:
  - compare, advance the scrambler, length counter +1 (saturates at 16'hFFFF)
- On eof in PKT:
  - the length counter includes the eof beat
  - if length != latched size, `err_len_cnt` +1
  - `pkt_cnt` +1, go to IDLE
- Framing violations (`err_frame_cnt` +1):
  - sof inside PKT: the beat is still compared and advances the scrambler; the length restarts at 1, the size is re-latched, and the aborted packet is not counted.
  - valid without sof in IDLE: the beat is discarded, with no compare and no scrambler advance.
  - eof with sof absent in IDLE: counts as the same single violation as above.
- Every compared beat advances the scrambler whether it matches or not. Alignment is lost only through `clear` or `rst_n`.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset and `clear` are identical in effect:
  - state HUNT
  - `locked`=0, `err_data`=0, all counters 0
  - length counter 0, latched size 0
- `clear` or `rst_n` low coincident with a valid beat: reset wins and the beat is ignored.
- Compare latency: `err_data` pulses, and `err_data_cnt` updates, on the cycle after the offending beat.
- `pkt_cnt`, `err_len_cnt` and `err_frame_cnt` update on the cycle after the eof or violating beat.
- `locked` rises on the cycle after the first sof beat.
- Back-to-back packets (eof beat followed directly by a sof beat) are supported with no idle cycle.
- Gaps (valid low) inside a packet are allowed and have no effect on state or scrambler.
- After `clear`, the generator must be restarted (scrambler re-seeded) for the checker to relock.

## Test plan
- Generator with pkt_size=8, pause_size=4, start high for 10 packets into checker: pkt_cnt=10, all error counters 0, `locked`=1, `err_data` never high.
- Same stream with bit 0 of beat 3 of packet 2 flipped: exactly one `err_data` pulse, one cycle after that beat. Final counts: err_data_cnt=1, pkt_cnt=10.
- Generator pkt_size=8, checker pkt_size=9: err_len_cnt equals pkt_cnt, err_data_cnt=0.
- In PKT, inject sof on beat 4 of an 8-beat packet: err_frame_cnt=1, the aborted packet is not counted, and the new packet closes at eof with a length check.
- Mid-packet `rst_n` low for 1 cycle, then the generator is restarted: counters read 0 after reset, `locked`=0 until the next sof, and the new run is error-free.
- Force err_len_cnt to 16'hFFFE via a long mismatched run, then 3 more bad packets: the counter holds at 16'hFFFF.
